// File: rtl/breath_led_core.sv
// breath_led_core: PWM breathing engine ramping LED duty 0 -> MAX -> 0 with programmable end holds.
// Optional feature macro BREATH_LED_GAMMA_EN: drive the LED from a registered (duty*duty) >> PWM_BITS.
module breath_led_core #(
    parameter int PWM_BITS = 8,
    parameter int PRE_BITS = 16,
    parameter int CNT_BITS = 16
) (
    input  logic                ACLK,
    input  logic                ARESETN,
    input  logic                cfg_en,
    input  logic [PRE_BITS-1:0] cfg_prescale,
    input  logic [PWM_BITS-1:0] cfg_step,
    input  logic [7:0]          cfg_hold,
    output logic                led_out,
    output logic [PWM_BITS-1:0] duty,
    output logic [CNT_BITS-1:0] breath_cnt,
    output logic                busy
);

    localparam logic [PWM_BITS-1:0] DUTY_MAX = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] PWM_ONE  = PWM_BITS'(1);
    localparam logic [PRE_BITS-1:0] PRE_ONE  = PRE_BITS'(1);
    localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RAMP_UP = 3'd1,
        HOLD_HI = 3'd2,
        RAMP_DN = 3'd3,
        HOLD_LO = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [PRE_BITS-1:0] r_pre_cnt;
    logic [PRE_BITS-1:0] r_pre_s;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [PWM_BITS-1:0] r_step_s;
    logic [PWM_BITS-1:0] r_duty;
    logic [7:0]          r_hold_s;
    logic [7:0]          r_hold_cnt;
    logic [CNT_BITS-1:0] r_breath_cnt;
    logic                r_led;

    logic                w_active;
    logic                w_tick;
    logic                w_pb;
    logic                w_hold_done;
    logic [PWM_BITS-1:0] w_step_eff;
    logic [PWM_BITS:0]   w_sum;
    logic [PWM_BITS:0]   w_diff;
    logic [PWM_BITS-1:0] w_duty_up;
    logic [PWM_BITS-1:0] w_duty_dn;
    logic                w_up_full;
    logic                w_dn_empty;
    logic [PWM_BITS-1:0] w_duty_next;
    logic [7:0]          w_hold_next;
    logic                w_breath_inc;

    // Timebase: prescaled tick, and the PWM period boundary where pwm_cnt wraps.
    assign w_active    = (r_state != IDLE);
    assign w_tick      = w_active && (r_pre_cnt == r_pre_s);
    assign w_pb        = w_tick && (r_pwm_cnt == DUTY_MAX);
    // >= rather than == so a hold shortened at a boundary cannot overshoot and wrap.
    assign w_hold_done = (r_hold_cnt >= r_hold_s);

    // Saturating duty arithmetic one bit wider than the duty; a step of 0 behaves as 1.
    assign w_step_eff  = (r_step_s == '0) ? PWM_ONE : r_step_s;
    assign w_sum       = {1'b0, r_duty} + {1'b0, w_step_eff};
    assign w_diff      = {1'b0, r_duty} - {1'b0, w_step_eff};
    assign w_duty_up   = w_sum[PWM_BITS]  ? DUTY_MAX : w_sum[PWM_BITS-1:0];
    assign w_duty_dn   = w_diff[PWM_BITS] ? '0       : w_diff[PWM_BITS-1:0];
    assign w_up_full   = (w_duty_up == DUTY_MAX);
    assign w_dn_empty  = (w_duty_dn == '0);

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Leaving a hold applies the next ramp step at the same boundary, so a hold lasts hold_s+1 periods.
    always_comb begin
        w_state_next = r_state;
        w_duty_next  = r_duty;
        w_hold_next  = r_hold_cnt;
        w_breath_inc = 1'b0;
        if (!cfg_en) begin
            w_state_next = IDLE;
            w_duty_next  = '0;
            w_hold_next  = '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    w_state_next = RAMP_UP;
                    w_duty_next  = '0;
                    w_hold_next  = '0;
                end
                RAMP_UP, HOLD_LO: begin
                    if (w_pb) begin
                        if ((r_state == HOLD_LO) && !w_hold_done) begin
                            w_hold_next = r_hold_cnt + 8'd1;
                        end else begin
                            w_duty_next  = w_duty_up;
                            w_hold_next  = '0;
                            w_state_next = w_up_full ? HOLD_HI : RAMP_UP;
                        end
                    end
                end
                HOLD_HI, RAMP_DN: begin
                    if (w_pb) begin
                        if ((r_state == HOLD_HI) && !w_hold_done) begin
                            w_hold_next = r_hold_cnt + 8'd1;
                        end else begin
                            w_duty_next  = w_duty_dn;
                            w_hold_next  = '0;
                            w_state_next = w_dn_empty ? HOLD_LO : RAMP_DN;
                            w_breath_inc = w_dn_empty;
                        end
                    end
                end
                default: begin
                    w_state_next = IDLE;
                    w_duty_next  = '0;
                    w_hold_next  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_pre_cnt    <= '0;
            r_pwm_cnt    <= '0;
            r_pre_s      <= '0;
            r_step_s     <= '0;
            r_hold_s     <= '0;
            r_duty       <= '0;
            r_hold_cnt   <= '0;
            r_breath_cnt <= '0;
        end else begin
            r_duty     <= w_duty_next;
            r_hold_cnt <= w_hold_next;
            if (w_breath_inc) begin
                r_breath_cnt <= r_breath_cnt + CNT_ONE;
            end
            if (!cfg_en || !w_active) begin
                r_pre_cnt <= '0;
                r_pwm_cnt <= '0;
            end else if (w_tick) begin
                r_pre_cnt <= '0;
                r_pwm_cnt <= r_pwm_cnt + PWM_ONE;
            end else begin
                r_pre_cnt <= r_pre_cnt + PRE_ONE;
            end
            // Config is sampled only at start-up and at period boundaries, keeping each period glitch-free.
            if ((cfg_en && !w_active) || w_pb) begin
                r_pre_s  <= cfg_prescale;
                r_step_s <= cfg_step;
                r_hold_s <= cfg_hold;
            end
        end
    end

`ifdef BREATH_LED_GAMMA_EN
    logic [PWM_BITS-1:0] r_duty_eff;
    logic [PWM_BITS-1:0] r_pwm_d;
    logic                r_run_d;
    logic [2*PWM_BITS-1:0] w_duty_sq;

    assign w_duty_sq = {{PWM_BITS{1'b0}}, r_duty} * {{PWM_BITS{1'b0}}, r_duty};

    // The squared duty is registered, so pwm_cnt and run state are delayed by one clock to stay aligned.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_duty_eff <= '0;
            r_pwm_d    <= '0;
            r_run_d    <= 1'b0;
            r_led      <= 1'b0;
        end else begin
            r_duty_eff <= PWM_BITS'(w_duty_sq >> PWM_BITS);
            r_pwm_d    <= r_pwm_cnt;
            r_run_d    <= w_active && cfg_en;
            r_led      <= cfg_en && r_run_d && (r_pwm_d < r_duty_eff);
        end
    end
`else
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_led <= 1'b0;
        end else begin
            r_led <= cfg_en && w_active && (r_pwm_cnt < r_duty);
        end
    end
`endif

    assign led_out    = r_led;
    assign duty       = r_duty;
    assign breath_cnt = r_breath_cnt;
    assign busy       = w_active;

endmodule

// File: tb/tb_breath_led_core.sv
// tb_breath_led_core: scoreboard bench for breath_led_core at PWM_BITS=4, CNT_BITS=3.
// Per-period expectations (duty, LED-high clocks, breath count) are queued when each run is started.
`timescale 1ns/1ps
module tb_breath_led_core;

    localparam int PWM_BITS = 4;
    localparam int PRE_BITS = 16;
    localparam int CNT_BITS = 3;
    localparam int PMAX     = 15;

    logic                ACLK = 1'b0;
    logic                ARESETN = 1'b0;
    logic                cfg_en = 1'b0;
    logic [PRE_BITS-1:0] cfg_prescale = '0;
    logic [PWM_BITS-1:0] cfg_step = '0;
    logic [7:0]          cfg_hold = '0;
    logic                led_out;
    logic [PWM_BITS-1:0] duty;
    logic [CNT_BITS-1:0] breath_cnt;
    logic                busy;

    breath_led_core #(
        .PWM_BITS(PWM_BITS),
        .PRE_BITS(PRE_BITS),
        .CNT_BITS(CNT_BITS)
    ) dut (
        .ACLK        (ACLK),
        .ARESETN     (ARESETN),
        .cfg_en      (cfg_en),
        .cfg_prescale(cfg_prescale),
        .cfg_step    (cfg_step),
        .cfg_hold    (cfg_hold),
        .led_out     (led_out),
        .duty        (duty),
        .breath_cnt  (breath_cnt),
        .busy        (busy)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        int duty;
        int hi;
        int breath;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   breath_model = 0;

    task automatic check_val(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end else begin
            $display("ok   %s = %0d", tag, actual);
        end
    endtask

    function automatic int duty_eff(input int d);
`ifdef BREATH_LED_GAMMA_EN
        return (d * d) >> PWM_BITS;
`else
        return d;
`endif
    endfunction

    // Breathing waveform written as a sequence of per-period duties: one start period at 0, ramp up,
    // hold extra periods at MAX, ramp down (breath counted on reaching 0), hold extra periods at 0.
    task automatic push_run(input int step, input int hold, input int pre, input int nper);
        int   dq[$];
        int   bq[$];
        int   s;
        int   v;
        exp_t e;
        s = (step == 0) ? 1 : step;
        v = 0;
        dq.push_back(0);
        bq.push_back(breath_model);
        while (dq.size() <= nper) begin
            while (v < PMAX) begin
                v = (v + s > PMAX) ? PMAX : v + s;
                dq.push_back(v);
                bq.push_back(breath_model);
            end
            repeat (hold) begin
                dq.push_back(PMAX);
                bq.push_back(breath_model);
            end
            while (v > 0) begin
                v = (v - s < 0) ? 0 : v - s;
                if (v == 0) breath_model = (breath_model + 1) % (1 << CNT_BITS);
                dq.push_back(v);
                bq.push_back(breath_model);
            end
            repeat (hold) begin
                dq.push_back(0);
                bq.push_back(breath_model);
            end
        end
        for (int k = 0; k < nper; k++) begin
            e.duty   = dq[k];
            e.hi     = (pre + 1) * duty_eff(dq[k]);
            e.breath = bq[k];
            exp_q.push_back(e);
        end
        breath_model = bq[nper];
    endtask

    // Called at the negedge right after a period boundary; consumes one queue entry per period.
    task automatic measure(input int nper, input int pre, input string name, input int mid_step);
        exp_t e;
        int   hi;
        int   d_obs;
        int   b_obs;
        int   len;
        len = 16 * (pre + 1);
        for (int k = 0; k < nper; k++) begin
            d_obs = int'(duty);
            b_obs = int'(breath_cnt);
            hi = 0;
            for (int j = 0; j < len; j++) begin
                if (k == 0 && mid_step >= 0 && j == len / 2) cfg_step = PWM_BITS'(mid_step);
                @(negedge ACLK);
                hi += int'(led_out);
            end
            check_val($sformatf("%s p%0d sb_avail", name, k), (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_val($sformatf("%s p%0d duty", name, k), d_obs, e.duty);
                check_val($sformatf("%s p%0d led_hi", name, k), hi, e.hi);
                check_val($sformatf("%s p%0d breath", name, k), b_obs, e.breath);
            end
        end
    endtask

    task automatic start_run(input int step, input int hold, input int pre, input int nper);
        cfg_step     = PWM_BITS'(step);
        cfg_hold     = 8'(hold);
        cfg_prescale = PRE_BITS'(pre);
        ARESETN      = 1'b1;
        cfg_en       = 1'b1;
        push_run(step, hold, pre, nper);
        @(negedge ACLK);
`ifdef BREATH_LED_GAMMA_EN
        @(negedge ACLK);
`endif
    endtask

    task automatic stop_run(input string name);
        cfg_en = 1'b0;
        @(negedge ACLK);
        check_val({name, " stop led"}, led_out, 0);
        check_val({name, " stop duty"}, duty, 0);
        check_val({name, " stop busy"}, busy, 0);
        check_val({name, " stop breath"}, breath_cnt, breath_model);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   b_keep;

        // Reset held with cfg_en high: everything stays zero and idle.
        cfg_en = 1'b1;
        cfg_step = 4'd4;
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            check_val($sformatf("reset c%0d led", i), led_out, 0);
            check_val($sformatf("reset c%0d duty", i), duty, 0);
            check_val($sformatf("reset c%0d breath", i), breath_cnt, 0);
            check_val($sformatf("reset c%0d busy", i), busy, 0);
        end

        // Basic breath: 0,4,8,12,15,11,7,3,0 with breath_cnt=1 once 0 is reached.
        start_run(4, 0, 0, 10);
        check_val("t2 busy", busy, 1);
        measure(10, 0, "t2", -1);
        stop_run("t2");

        // Prescale 2, full step, hold 2: three periods at MAX and three at 0, 48 clocks each.
        start_run(15, 2, 2, 8);
        measure(8, 2, "t3", -1);
        stop_run("t3");

        // Step 0 acts as step 1, no wrap at either end.
        start_run(0, 1, 0, 36);
        measure(36, 0, "t4", -1);
        stop_run("t4");

        // Disable mid ramp-down at duty 7, then restart from 0.
        start_run(4, 0, 0, 6);
        measure(6, 0, "t5", -1);
        check_val("t5 duty before drop", duty, 7);
        b_keep = int'(breath_cnt);
        repeat (5) @(negedge ACLK);
        cfg_en = 1'b0;
        @(negedge ACLK);
        check_val("t5 drop led", led_out, 0);
        check_val("t5 drop duty", duty, 0);
        check_val("t5 drop busy", busy, 0);
        check_val("t5 drop breath", breath_cnt, b_keep);
        start_run(4, 0, 0, 3);
        measure(3, 0, "t5r", -1);
        stop_run("t5r");

        // Step 4 -> 8 mid-period: that boundary still adds the old step, the next one the new.
        start_run(4, 0, 0, 2);
        measure(2, 0, "t6a", -1);
        e.duty = 8;  e.hi = duty_eff(8);  e.breath = breath_model; exp_q.push_back(e);
        e.duty = 12; e.hi = duty_eff(12); e.breath = breath_model; exp_q.push_back(e);
        e.duty = 15; e.hi = duty_eff(15); e.breath = breath_model; exp_q.push_back(e);
        e.duty = 7;  e.hi = duty_eff(7);  e.breath = breath_model; exp_q.push_back(e);
        breath_model = (breath_model + 1) % (1 << CNT_BITS);
        e.duty = 0;  e.hi = 0;            e.breath = breath_model; exp_q.push_back(e);
        measure(5, 0, "t6b", 8);
        stop_run("t6");

        // Breath counter wrap with a 3-bit counter: one breath every two periods.
        start_run(15, 0, 0, 20);
        measure(20, 0, "wrap", -1);
        stop_run("wrap");

        check_val("scoreboard drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
